// File: rtl/bch_pkg.sv
// Shared GF(2^M) helpers and state type for the BCH syndrome unit.
// Field arithmetic is done on 8-bit operands so one function covers M = 3..8.
package bch_pkg;

   typedef enum logic [0:0] {COLLECT, OUTPUT} synd_state_t;

   // Shift-and-add multiply, reducing by prim_poly after every shift
   function automatic logic [7:0] gf_mul_const(
      input logic [7:0] value,
      input logic [7:0] c,
      input logic [8:0] prim_poly,
      input int         m
   );
      logic [8:0] acc;
      acc = '0;
      for (int i = 7; i >= 0; i--) begin
         if (i < m) begin
            acc = acc << 1;
            if (acc[m]) acc = acc ^ prim_poly;
            if (c[i]) acc = acc ^ {1'b0, value};
         end
      end
      return acc[7:0];
   endfunction

   function automatic logic [7:0] gf_alpha_pow(
      input int         j,
      input logic [8:0] prim_poly,
      input int         m
   );
      logic [8:0] p;
      p = 9'd1;
      for (int k = 0; k < j; k++) begin
         p = p << 1;
         if (p[m]) p = p ^ prim_poly;
      end
      return p[7:0];
   endfunction

endpackage

// File: rtl/bch_synd_cell.sv
// One syndrome accumulator S_J: S <= S * alpha^J + bit on every enabled beat.
// nz flags a non-zero next value so the top can register the all-zero flag.
module bch_synd_cell
   import bch_pkg::*;
#(
   parameter int         M         = 4,
   parameter int         J         = 1,
   parameter logic [M:0] PRIM_POLY = 5'b10011
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         in_bit,
   output logic [M-1:0] s,
   output logic         nz
);

   localparam logic [8:0] POLY9 = 9'(PRIM_POLY);
   localparam logic [7:0] ALPHA = gf_alpha_pow(J, POLY9, M);

   logic [7:0] s_ext;
   logic [7:0] nxt;

   always_comb begin
      s_ext = '0;
      s_ext[M-1:0] = s;
      nxt = gf_mul_const(s_ext, ALPHA, POLY9, M) ^ 8'(in_bit);
      nz = |nxt;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         s <= '0;
      end else if (en) begin
         s <= nxt[M-1:0];
      end
   end

endmodule

// File: rtl/bch_syndrome_unit.sv
// Bit-serial BCH syndrome calculator: collects one frame MSB first,
// then holds S_1..S_2T with zero and length-error flags until taken.
module bch_syndrome_unit
   import bch_pkg::*;
#(
   parameter int         M         = 4,
   parameter int         N         = 15,
   parameter int         T         = 2,
   parameter logic [M:0] PRIM_POLY = 5'b10011
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic             in_last,
   output logic             synd_valid,
   input  logic             synd_ready,
   output logic [2*T*M-1:0] synd_data,
   output logic             synd_zero,
   output logic             len_err
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   if (N > (1 << M) - 1 || PRIM_POLY[M] == 1'b0) begin : g_bad_cfg
      $fatal(1, "bch_syndrome_unit: bad N or PRIM_POLY");
   end

   synd_state_t     state;
   synd_state_t     state_next;
   logic [CW-1:0]   cnt;
   logic            zero_q;
   logic            len_q;
   logic            accept;
   logic            at_end;
   logic            end_acc;
   logic            clr;
   logic [2*T-1:0]  nz;

   always_comb begin
      state_next = state;
      in_ready   = (state == COLLECT);
      synd_valid = (state == OUTPUT);
      accept     = in_valid & in_ready;
      at_end     = (cnt == LAST_CNT);
      end_acc    = accept & (in_last | at_end);
      clr        = synd_valid & synd_ready;
      if (end_acc) begin
         state_next = OUTPUT;
      end else if (clr) begin
         state_next = COLLECT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= COLLECT;
      end else begin
         state <= state_next;
      end
   end

   // Counter holds at the final beat, so it never needs to wrap
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt    <= '0;
         zero_q <= 1'b0;
         len_q  <= 1'b0;
      end else if (end_acc) begin
         zero_q <= ~|nz;
         len_q  <= in_last ^ at_end;
      end else if (accept) begin
         cnt <= cnt + 1'b1;
      end
   end

   for (genvar j = 0; j < 2 * T; j++) begin : g_cell
      bch_synd_cell #(
         .M         (M),
         .J         (j + 1),
         .PRIM_POLY (PRIM_POLY)
      ) u_cell (
         .clk    (clk),
         .rst    (rst),
         .clr    (clr),
         .en     (accept),
         .in_bit (in_bit),
         .s      (synd_data[j*M +: M]),
         .nz     (nz[j])
      );
   end

   assign synd_zero = zero_q;
   assign len_err   = len_q;

endmodule

// File: tb/tb_bch_syndrome_unit.sv
// Directed bench for bch_syndrome_unit with a power-sum syndrome model.
// Expected S_j = XOR of alpha^(i*j) over the set coefficients r_i.
module tb_bch_syndrome_unit;

   localparam int M = 4;
   localparam int N = 15;
   localparam int T = 2;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_bit;
   logic        in_last;
   logic        synd_valid;
   logic        synd_ready;
   logic [15:0] synd_data;
   logic        synd_zero;
   logic        len_err;

   bch_syndrome_unit #(
      .M         (M),
      .N         (N),
      .T         (T),
      .PRIM_POLY (5'b10011)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bit     (in_bit),
      .in_last    (in_last),
      .synd_valid (synd_valid),
      .synd_ready (synd_ready),
      .synd_data  (synd_data),
      .synd_zero  (synd_zero),
      .len_err    (len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        exp_armed = 1'b0;
   logic [15:0] exp_data  = '0;
   logic        exp_zero  = 1'b0;
   logic        exp_len   = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, req);
      end
   endtask

   // r[i] is the coefficient of x^i; L coefficients were received
   function automatic logic [15:0] model(input logic [15:0] r, input int L);
      logic [3:0]  apow [15];
      logic [4:0]  a;
      logic [15:0] res;
      a = 5'd1;
      res = '0;
      for (int e = 0; e < 15; e++) begin
         apow[e] = a[3:0];
         a = a << 1;
         if (a[4]) a = a ^ 5'b10011;
      end
      for (int j = 1; j <= 2 * T; j++) begin
         logic [3:0] s;
         s = '0;
         for (int i = 0; i < L; i++) begin
            if (r[i]) s = s ^ apow[(i * j) % 15];
         end
         res[(j-1)*4 +: 4] = s;
      end
      return res;
   endfunction

   always @(negedge clk) begin
      if (!rst && synd_valid) begin
         check("in_ready_in_output", in_ready, 1'b0);
         if (exp_armed) begin
            check("synd_data", synd_data, exp_data);
            check("synd_zero", synd_zero, exp_zero);
            check("len_err", len_err, exp_len);
         end else begin
            check("synd_valid_unexpected", synd_valid, 1'b0);
         end
      end
   end

   // Called at posedge+1; leaves time at posedge+1 after the final accept
   task automatic send(input logic [15:0] bits, input int len,
                       input bit has_last);
      exp_data = model(bits, len);
      exp_zero = (exp_data == 16'h0);
      exp_len  = !(len == N && has_last);
      for (int k = 0; k < len; k++) begin
         in_valid = 1'b1;
         in_bit   = bits[len-1-k];
         in_last  = has_last && (k == len - 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_bit   = 1'b0;
      exp_armed = 1'b1;
      check("latency", synd_valid, 1'b1);
      for (int t = 0; t < 20 && !synd_valid; t++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic take(input int hold);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
      end
      synd_ready = 1'b1;
      @(posedge clk);
      #1;
      synd_ready = 1'b0;
      exp_armed  = 1'b0;
      check("valid_after_take", synd_valid, 1'b0);
      check("ready_after_take", in_ready, 1'b1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      check({tag, "_synd_valid"}, synd_valid, 1'b0);
      check({tag, "_synd_data"}, synd_data, 16'h0);
      check({tag, "_synd_zero"}, synd_zero, 1'b0);
      check({tag, "_len_err"}, len_err, 1'b0);
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_bit     = 1'b0;
      in_last    = 1'b0;
      synd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst = 1'b0;

      check("model_pin_r14", model(16'h4000, 15), 16'hEFD9);
      check("model_pin_gen", model(16'h01D1, 15), 16'h0000);
      check("model_pin_r0", model(16'h0001, 15), 16'h1111);

      send(16'h0000, 15, 1'b1);
      check("zero_frame_data", synd_data, 16'h0000);
      check("zero_frame_flag", synd_zero, 1'b1);
      check("zero_frame_len", len_err, 1'b0);
      take(0);

      send(16'h01D1, 15, 1'b1);
      check("gen_poly_data", synd_data, 16'h0000);
      check("gen_poly_flag", synd_zero, 1'b1);
      take(1);

      send(16'h4000, 15, 1'b1);
      check("r14_data", synd_data, 16'hEFD9);
      check("r14_flag", synd_zero, 1'b0);
      take(0);

      send(16'h0001, 15, 1'b1);
      check("r0_data", synd_data, 16'h1111);
      take(5);
      check("r0_after_hold", synd_data, 16'h0000);

      send(16'h02CE, 10, 1'b1);
      check("short_len_err", len_err, 1'b1);
      take(2);

      send(16'h5A3C, 15, 1'b1);
      check("full_after_short_len", len_err, 1'b0);
      take(0);

      send(16'h1234, 15, 1'b0);
      check("no_last_len_err", len_err, 1'b1);
      take(0);

      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1;
         in_bit   = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("midframe_rst");
      rst = 1'b0;

      send(16'h0000, 15, 1'b1);
      check("post_rst_data", synd_data, 16'h0000);
      check("post_rst_flag", synd_zero, 1'b1);
      check("post_rst_len", len_err, 1'b0);
      take(0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
